// File: rtl/dma_bus_arbiter.sv
// Cycle-stealing bus arbiter between a 6502 core and NREQ DMA requesters.
// Define DMA_ARB_RDY_ON_WRITE_EN for cores whose RDY also halts write cycles.
module dma_bus_arbiter #(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 8,
  parameter int CPU_GAP   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_rw,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            cpu_ready,
  output logic            dma_sel,
  output logic [2:0]      dma_owner
);

  localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [3:0]    GAP_LOAD   = 4'(CPU_GAP);

  typedef enum logic [1:0] {S_CPU, S_HALT, S_GRANT} state_t;

  state_t          r_state, w_stateNext;
  logic [2:0]      r_rrPtr, w_rrNext;
  logic [2:0]      r_owner, w_ownerNext;
  logic [2:0]      w_winner, w_idx;
  logic [BW-1:0]   r_burst, w_burstNext;
  logic [3:0]      r_gap, w_gapNext;
  logic [NREQ-1:0] r_gnt, w_gntNext;
  logic            r_ready, w_readyNext;
  logic            r_sel, w_selNext;
  logic [7:0]      w_req8;
  logic            w_anyReq, w_found, w_frozen;

  assign w_req8   = 8'(req);
  assign w_anyReq = |req;

`ifdef DMA_ARB_RDY_ON_WRITE_EN
  assign w_frozen = 1'b1;
`else
  // NMOS cores keep running through write cycles; only a read actually stops them.
  assign w_frozen = cpu_rw;
`endif

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = 3'((int'(r_rrPtr) + i) % NREQ);
      if (!w_found && w_req8[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_rrNext    = r_rrPtr;
    w_ownerNext = r_owner;
    w_burstNext = r_burst;
    w_gapNext   = r_gap;
    case (r_state)
      S_CPU: begin
        if (r_gap != 4'd0) w_gapNext = r_gap - 4'd1;
        if (w_anyReq && r_gap == 4'd0) w_stateNext = S_HALT;
      end
      S_HALT: begin
        if (w_frozen) begin
          if (w_anyReq) begin
            w_stateNext = S_GRANT;
            w_ownerNext = w_winner;
            w_rrNext    = (w_winner == 3'(NREQ - 1)) ? 3'd0 : w_winner + 3'd1;
            w_burstNext = '0;
          end else begin
            w_stateNext = S_CPU;
          end
        end
      end
      S_GRANT: begin
        // Grants always fall back to the CPU so the core runs between bursts.
        if (!w_req8[r_owner] || (MAX_BURST != 0 && r_burst == BURST_LAST)) begin
          w_stateNext = S_CPU;
          w_gapNext   = GAP_LOAD;
        end else begin
          w_burstNext = r_burst + 1'b1;
        end
      end
      default: w_stateNext = S_CPU;
    endcase

    w_readyNext = (w_stateNext == S_CPU);
    w_selNext   = (w_stateNext == S_GRANT);
    for (int j = 0; j < NREQ; j++) begin
      w_gntNext[j] = w_selNext && (w_ownerNext == 3'(j));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CPU;
      r_rrPtr <= '0;
      r_owner <= '0;
      r_burst <= '0;
      r_gap   <= '0;
      r_gnt   <= '0;
      r_ready <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_rrPtr <= w_rrNext;
      r_owner <= w_ownerNext;
      r_burst <= w_burstNext;
      r_gap   <= w_gapNext;
      r_gnt   <= w_gntNext;
      r_ready <= w_readyNext;
      r_sel   <= w_selNext;
    end
  end

  assign gnt       = r_gnt;
  assign cpu_ready = r_ready;
  assign dma_sel   = r_sel;
  assign dma_owner = r_owner;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: two instances (burst 8 and burst 4)
// checked every cycle against a transaction-level model plus directed literals.
module tb_dma_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int CPU_GAP = 1;
  localparam int RUN = 0, STALL = 1, DMA = 2;

  typedef struct {
    int mode;
    int owner;
    int nextStart;
    int used;
    int gapLeft;
  } mdl_t;

  logic            clk, reset, cpuRw;
  logic [NREQ-1:0] reqA, reqB;
  logic [NREQ-1:0] gntA, gntB;
  logic            readyA, readyB, selA, selB;
  logic [2:0]      ownerA, ownerB;
  int              checks = 0, passes = 0;
  bit              started = 0;
  mdl_t            mA, mB;

  dma_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(8), .CPU_GAP(CPU_GAP)) dutA (
    .clk(clk), .reset(reset), .cpu_rw(cpuRw), .req(reqA),
    .gnt(gntA), .cpu_ready(readyA), .dma_sel(selA), .dma_owner(ownerA));

  dma_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(4), .CPU_GAP(CPU_GAP)) dutB (
    .clk(clk), .reset(reset), .cpu_rw(cpuRw), .req(reqB),
    .gnt(gntB), .cpu_ready(readyB), .dma_sel(selB), .dma_owner(ownerB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdlInit();
    mdl_t m;
    m.mode = RUN; m.owner = 0; m.nextStart = 0; m.used = 0; m.gapLeft = 0;
    return m;
  endfunction

  // One CPU cycle of bus-sharing behaviour, phrased as who owns the bus.
  function automatic mdl_t mdlStep(mdl_t m, logic [NREQ-1:0] r, logic rw, int maxBurst);
    mdl_t n;
    bit   frozen, found;
    int   c;
    n = m;
    found = 0;
`ifdef DMA_ARB_RDY_ON_WRITE_EN
    frozen = 1;
`else
    frozen = rw;
`endif
    if (m.mode == RUN) begin
      if (m.gapLeft > 0) n.gapLeft = m.gapLeft - 1;
      else if (r != 0) n.mode = STALL;
    end else if (m.mode == STALL) begin
      if (frozen && r == 0) n.mode = RUN;
      else if (frozen) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m.nextStart + k) % NREQ;
          if (!found && r[c]) begin
            found = 1;
            n.mode = DMA;
            n.owner = c;
            n.nextStart = (c + 1) % NREQ;
            n.used = 1;
          end
        end
      end
    end else begin
      if (!r[m.owner] || (maxBurst != 0 && m.used >= maxBurst)) begin
        n.mode = RUN;
        n.gapLeft = CPU_GAP;
      end else begin
        n.used = m.used + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [NREQ-1:0] expGnt(mdl_t m);
    return (m.mode == DMA) ? (NREQ'(1) << m.owner) : '0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mA <= mdlInit();
      mB <= mdlInit();
    end else begin
      mA <= mdlStep(mA, reqA, cpuRw, 8);
      mB <= mdlStep(mB, reqB, cpuRw, 4);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      checkOutput("A.gnt", 32'(gntA), 32'(expGnt(mA)));
      checkOutput("A.cpu_ready", 32'(readyA), 32'(mA.mode == RUN));
      checkOutput("A.dma_sel", 32'(selA), 32'(mA.mode == DMA));
      checkOutput("A.dma_owner", 32'(ownerA), 32'(mA.owner));
      checkOutput("B.gnt", 32'(gntB), 32'(expGnt(mB)));
      checkOutput("B.cpu_ready", 32'(readyB), 32'(mB.mode == RUN));
      checkOutput("B.dma_sel", 32'(selB), 32'(mB.mode == DMA));
      checkOutput("B.dma_owner", 32'(ownerB), 32'(mB.owner));
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] a, input logic [NREQ-1:0] b, input logic rw);
    reqA  = a;
    reqB  = b;
    cpuRw = rw;
  endtask

  task automatic waitCycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int runs[$];
  int runOwners[$];
  int runDmaOwners[$];
  int runLen, curOwner, readyBetween;
  bit sawRun1;

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(2);
    checkOutput("reset cpu_ready", 32'(readyA), 32'd1);
    checkOutput("reset gnt", 32'(gntA), 32'd0);
    checkOutput("reset dma_sel", 32'(selA), 32'd0);
    checkOutput("reset dma_owner", 32'(ownerA), 32'd0);
    reset = 1'b0;
    started = 1;
    waitCycle(1);

    // Single request while the CPU reads, then the post-grant gap and a HALT abort.
    applyStimulus(2'b01, 2'b00, 1'b1);
    waitCycle(1);
    checkOutput("t1 stall ready", 32'(readyA), 32'd0);
    checkOutput("t1 stall gnt", 32'(gntA), 32'd0);
    waitCycle(1);
    checkOutput("t1 grant gnt", 32'(gntA), 32'h1);
    checkOutput("t1 grant sel", 32'(selA), 32'd1);
    waitCycle(3);
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(1);
    checkOutput("t1 release ready", 32'(readyA), 32'd1);
    checkOutput("t1 release gnt", 32'(gntA), 32'd0);
    applyStimulus(2'b01, 2'b00, 1'b1);
    waitCycle(1);
    checkOutput("t1 gap holds ready", 32'(readyA), 32'd1);
    waitCycle(1);
    checkOutput("t1 after gap ready", 32'(readyA), 32'd0);
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(1);
    checkOutput("abort ready", 32'(readyA), 32'd1);
    checkOutput("abort gnt", 32'(gntA), 32'd0);
    waitCycle(2);

`ifdef DMA_ARB_RDY_ON_WRITE_EN
    // RDY halts writes too: grant two cycles after the request regardless of R/W.
    applyStimulus(2'b01, 2'b00, 1'b0);
    waitCycle(1);
    checkOutput("rdyw halt gnt", 32'(gntA), 32'd0);
    waitCycle(1);
    checkOutput("rdyw grant gnt", 32'(gntA), 32'h1);
`else
    // BRK push: three writes keep the core running, the following read freezes it.
    applyStimulus(2'b10, 2'b00, 1'b0);
    waitCycle(1);
    checkOutput("nmos halt ready", 32'(readyA), 32'd0);
    for (int i = 0; i < 3; i++) begin
      waitCycle(1);
      checkOutput("nmos write gnt", 32'(gntA), 32'd0);
      checkOutput("nmos write ready", 32'(readyA), 32'd0);
    end
    applyStimulus(2'b10, 2'b00, 1'b1);
    waitCycle(1);
    checkOutput("nmos read gnt", 32'(gntA), 32'h2);
    checkOutput("nmos read owner", 32'(ownerA), 32'd1);
`endif
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(3);

    // Burst limit on instance A.
    applyStimulus(2'b01, 2'b00, 1'b1);
    runs.delete();
    runLen = 0; readyBetween = 0; sawRun1 = 0;
    for (int i = 0; i < 24; i++) begin
      waitCycle(1);
      if (gntA[0]) runLen++;
      else begin
        if (runLen > 0) begin
          runs.push_back(runLen);
          if (runs.size() == 1) sawRun1 = 1;
        end
        runLen = 0;
        if (sawRun1 && runs.size() == 1 && readyA) readyBetween++;
      end
    end
    checkOutput("burst run count", 32'(runs.size() >= 2), 32'd1);
    if (runs.size() >= 2) begin
      checkOutput("burst run1 len", 32'(runs[0]), 32'd8);
      checkOutput("burst run2 len", 32'(runs[1]), 32'd8);
    end
    checkOutput("burst cpu gap cycles", 32'(readyBetween), 32'd2);
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(3);

    // Round robin on instance B (burst 4) with both requesters held.
    applyStimulus(2'b00, 2'b11, 1'b1);
    runs.delete(); runOwners.delete(); runDmaOwners.delete();
    runLen = 0; curOwner = 9;
    for (int i = 0; i < 32; i++) begin
      waitCycle(1);
      if (gntB != 2'b00) begin
        if (runLen == 0) begin
          curOwner = (gntB == 2'b01) ? 0 : ((gntB == 2'b10) ? 1 : 9);
          runDmaOwners.push_back(int'(ownerB));
        end
        runLen++;
      end else if (runLen > 0) begin
        runs.push_back(runLen);
        runOwners.push_back(curOwner);
        runLen = 0;
      end
    end
    checkOutput("rr run count", 32'(runs.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < runs.size(); i++) begin
      checkOutput("rr run len", 32'(runs[i]), 32'd4);
      checkOutput("rr gnt owner", 32'(runOwners[i]), 32'(i % 2));
      checkOutput("rr dma_owner", 32'(runDmaOwners[i]), 32'(i % 2));
    end
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(3);

    // Asynchronous reset in the middle of a grant.
    applyStimulus(2'b01, 2'b00, 1'b1);
    waitCycle(2);
    checkOutput("pre-reset gnt", 32'(gntA), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset gnt", 32'(gntA), 32'd0);
    checkOutput("async reset sel", 32'(selA), 32'd0);
    checkOutput("async reset ready", 32'(readyA), 32'd1);
    checkOutput("async reset owner", 32'(ownerA), 32'd0);
    applyStimulus(2'b00, 2'b00, 1'b1);
    waitCycle(1);
    reset = 1'b0;
    waitCycle(2);
    checkOutput("post-reset ready", 32'(readyA), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
